// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out feeder for the serial sequence detectors. A WIDTH-bit
// word is accepted through a valid/ready handshake and shifted out one bit per
// clock, MSB first when MSB_FIRST=1, LSB first otherwise. Consecutive words
// stream with no idle gap; between words sout holds IDLE_BIT.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rstn         synchronous active-low reset
//   din          parallel word to serialize
//   din_valid    din holds a word to transfer
//   din_ready    block can accept a word this cycle (decoded from state only)
//   sout         serial bit (IDLE_BIT when not shifting)
//   sout_valid   sout carries a data bit
//   frame_start  high during the first bit of each word
//   busy         a word is currently being shifted out
// -----------------------------------------------------------------------------
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             last_bit;
   logic             take;

   // Move the register one place toward the output end; the vacated bit is
   // filled with zero but is never driven onto sout.
   function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
      if (MSB_FIRST) begin
         return {v[WIDTH-2:0], 1'b0};
      end else begin
         return {1'b0, v[WIDTH-1:1]};
      end
   endfunction

   // The output end of the shift register holds the bit on the wire.
   function automatic logic out_bit(input logic [WIDTH-1:0] v);
      if (MSB_FIRST) begin
         return v[WIDTH-1];
      end else begin
         return v[0];
      end
   endfunction

   // Ready is a pure state decode so the source never sees a loop through
   // din_valid; the last-bit cycle reopens the handshake for gapless streaming.
   assign last_bit  = (state == SHIFT) && (cnt == LAST_CNT);
   assign din_ready = (state == IDLE) || last_bit;
   assign take      = din_valid && din_ready;

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (take) begin
               shreg_nxt = din;
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (!last_bit) begin
               shreg_nxt = shift_one(shreg);
               cnt_nxt   = cnt + CNT_W'(1);
            end else if (take) begin
               shreg_nxt = din;
               cnt_nxt   = '0;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Outputs decode registered state only; din has no path to sout.
   assign sout        = (state == SHIFT) ? out_bit(shreg) : IDLE_BIT;
   assign sout_valid  = (state == SHIFT);
   assign busy        = (state == SHIFT);
   assign frame_start = (state == SHIFT) && (cnt == '0);

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] din;
   logic       din_valid;

   logic din_ready,   sout,   sout_valid,   frame_start,   busy;
   logic din_ready_l, sout_l, sout_valid_l, frame_start_l, busy_l;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .din         (din),
      .din_valid   (din_valid),
      .din_ready   (din_ready),
      .sout        (sout),
      .sout_valid  (sout_valid),
      .frame_start (frame_start),
      .busy        (busy)
   );

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
      .clk         (clk),
      .rstn        (rstn),
      .din         (din),
      .din_valid   (din_valid),
      .din_ready   (din_ready_l),
      .sout        (sout_l),
      .sout_valid  (sout_valid_l),
      .frame_start (frame_start_l),
      .busy        (busy_l)
   );

   // Reference model: a word in flight plus the index of the bit on the wire.
   bit         m_act;
   logic [7:0] m_word;
   int         m_idx;
   bit         m_acc;
   bit         chk_en;

   logic [31:0] cap, cap_l;
   int          cap_n, cap_ln;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [9:0] model_outputs();
      logic rdy, so_m, so_l, fs;
      rdy  = !m_act || (m_idx == 7);
      so_m = m_act ? m_word[7 - m_idx] : 1'b0;
      so_l = m_act ? m_word[m_idx]     : 1'b0;
      fs   = m_act && (m_idx == 0);
      return {rdy, so_m, m_act, fs, m_act, rdy, so_l, m_act, fs, m_act};
   endfunction

   // One clock: check outputs at the falling edge, then drive inputs for the
   // coming rising edge and advance the model across it.
   task automatic cycle(input logic r, input logic v, input logic [7:0] d);
      bit rdy;
      @(negedge clk);
      if (chk_en) begin
         chk("outputs",
             {22'd0, din_ready, sout, sout_valid, frame_start, busy,
              din_ready_l, sout_l, sout_valid_l, frame_start_l, busy_l},
             {22'd0, model_outputs()});
      end
      if (sout_valid)   begin cap   = {cap[30:0], sout};     cap_n++;  end
      if (sout_valid_l) begin cap_l = {cap_l[30:0], sout_l}; cap_ln++; end
      rstn      = r;
      din_valid = v;
      din       = d;
      @(posedge clk);
      rdy   = !m_act || (m_idx == 7);
      m_acc = 1'b0;
      if (!r) begin
         m_act = 1'b0;
         m_idx = 0;
      end else if (v && rdy) begin
         m_acc  = 1'b1;
         m_act  = 1'b1;
         m_word = d;
         m_idx  = 0;
      end else if (m_act) begin
         if (m_idx == 7) m_act = 1'b0;
         else            m_idx++;
      end
   endtask

   task automatic send(input logic [7:0] w);
      int n;
      n = 0;
      do begin
         cycle(1'b1, 1'b1, w);
         n++;
      end while (!m_acc && n < 20);
      if (!m_acc) chk("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00);
   endtask

   task automatic clr_cap();
      cap = '0; cap_l = '0; cap_n = 0; cap_ln = 0;
   endtask

   initial begin
      rstn = 1'b0; din_valid = 1'b0; din = 8'h00;
      m_act = 1'b0; m_idx = 0; m_word = 8'h00; m_acc = 1'b0; chk_en = 1'b0;
      clr_cap();

      // Reset held for two cycles, then ten idle cycles.
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      chk_en = 1'b1;
      #1;
      chk("reset_state", {28'd0, din_ready, sout, sout_valid, busy}, 32'b1000);
      idle(10);
      chk("idle_no_bits", cap_n, 0);

      // Single word, MSB first.
      clr_cap();
      send(8'b1001_0010);
      idle(9);
      chk("single_bits", cap[7:0], 8'b1001_0010);
      chk("single_cnt", cap_n, 8);

      // Back-to-back with no gap.
      clr_cap();
      send(8'hA5);
      send(8'h3C);
      idle(9);
      chk("b2b_bits", cap[15:0], 16'hA53C);
      chk("b2b_cnt", cap_n, 16);

      // Stall: offer 8'hFF while bit 3 of 8'h00 is on the wire.
      clr_cap();
      send(8'h00);
      idle(3);
      send(8'hFF);
      idle(9);
      chk("stall_bits", cap[15:0], 16'h00FF);
      chk("stall_cnt", cap_n, 16);

      // LSB-first instance.
      clr_cap();
      send(8'b0000_0110);
      idle(9);
      chk("lsb_bits", cap_l[7:0], 8'b0110_0000);
      chk("lsb_cnt", cap_ln, 8);

      // Reset during bit 4 of 8'hFF.
      clr_cap();
      send(8'hFF);
      idle(4);
      cycle(1'b0, 1'b0, 8'h00);
      #1;
      chk("midrst_idle", {29'd0, sout, sout_valid, busy}, 32'd0);
      chk("midrst_partial", cap_n, 5);
      clr_cap();
      cycle(1'b1, 1'b0, 8'h00);
      send(8'h5A);
      idle(9);
      chk("midrst_after", cap[7:0], 8'h5A);
      chk("midrst_after_cnt", cap_n, 8);

      // A word presented together with reset is not taken.
      cycle(1'b0, 1'b1, 8'h33);
      #1;
      chk("rst_word_ignored", {30'd0, busy, din_ready}, 32'b01);
      idle(2);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 63) != 0), $urandom_range(0, 1) != 0, 8'($urandom));
      end
      idle(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Upstream feeder for the serial sequence detectors; it converts parallel words into the one-bit-per-cycle stream those detectors consume.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, MSB first by default.
- Back-to-back words stream with no idle gap.
- Between words it drives a fixed idle level, so a downstream detector sees a deterministic stream.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- IDLE_BIT, 0, level driven on sout when no word is being shifted.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rstn  input  1  reset, synchronous, active-low.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial bit; connects to the detector's serial input.
- sout_valid  output  1  sout carries a data bit (not idle fill).
- frame_start  output  1  high during the first bit of each word.
- busy  output  1  a word is currently being shifted out.

Behaviour:
- Reset is synchronous, active-low, and sampled at the rising edge of clk.
  - While rstn=0 at an edge: go to IDLE, clear the shift register and bit counter.
  - Reset values: sout=IDLE_BIT, sout_valid=0, frame_start=0, busy=0, din_ready=1 from the first cycle after reset.
- Two states, IDLE and SHIFT. Registers: shift register [WIDTH-1:0]; bit counter of clog2(WIDTH) bits, counting 0..WIDTH-1.
- din_ready is decoded from state only and never depends on din_valid:
  - din_ready = (state==IDLE) OR (state==SHIFT AND cnt==WIDTH-1).
- A transfer happens at an edge where din_valid=1 and din_ready=1.
  - din is captured into the shift register.
  - cnt <= 0; state <= SHIFT.
- Latency: a word accepted at edge k drives its first bit on sout during the cycle after edge k.
  - The last bit appears during the cycle after edge k+WIDTH-1.
  - Throughput is one word per WIDTH cycles.
- SHIFT state outputs are all registered, with no combinational path from din to sout:
  - sout = current bit, taken from the shift-register MSB when MSB_FIRST=1, or the LSB when MSB_FIRST=0.
  - sout_valid=1 and busy=1.
  - frame_start=1 only when cnt==0.
- In SHIFT, each edge does one of the following:
  - cnt < WIDTH-1: shift by one toward the output end and increment cnt. Vacated bits are don't-care and never reach sout.
  - cnt == WIDTH-1 with a transfer: load the new word and set cnt=0. The new first bit follows the old last bit with zero gap.
  - cnt == WIDTH-1 without a transfer: state <= IDLE.
- IDLE outputs: sout=IDLE_BIT, sout_valid=0, busy=0, frame_start=0.
- din_valid=1 while din_ready=0 is legal and has no effect. The word is not captured, and the source must hold it until din_ready=1.
- din and din_valid changing mid-word do not disturb the word in flight.
- Reset asserted mid-word:
  - The partial word is dropped with no further bits.
  - sout returns to IDLE_BIT one edge after reset is sampled.
  - A word presented in the same cycle as reset is not accepted.

Test Plan:
- Reset then idle: hold rstn=0 for 2 cycles, release with din_valid=0 for 10 cycles → sout=0, sout_valid=0, busy=0, din_ready=1 throughout.
- Single word, MSB_FIRST=1: accept din=8'b1001_0010 at edge k.
  - Required: sout 1,0,0,1,0,0,1,0 on cycles k+1..k+8, with frame_start=1 only on cycle k+1.
  - Then idle: sout=0, sout_valid=0.
  - Fed into the 1001/010 detector, this stream yields exactly the expected detector pulses.
- Back-to-back: din_valid held high with words 8'hA5 then 8'h3C → 16 consecutive valid bits 1010_0101_0011_1100, no gap.
  - din_ready high only on the cycle before each load.
  - frame_start on bit 1 and bit 9.
- Stall: assert din_valid=1 with 8'hFF while bit 3 of 8'h00 is being shifted.
  - Required: 8'hFF is not taken until the last bit of 8'h00.
  - Then eight 1s follow immediately.
- LSB first: MSB_FIRST=0, din=8'b0000_0110 → sout 0,1,1,0,0,0,0,0.
- Mid-word reset: pull rstn low during bit 4 of 8'hFF.
  - Required: next cycle sout=IDLE_BIT, sout_valid=0, busy=0.
  - A new word accepted after release shifts out complete and correct.
